// File: rtl/pwcrack_pkg.sv
// Shared definitions for the password search engine.
//   - charset bounds: digits 0..25 map to 'a'..'z', 26..35 map to '0'..'9'
//   - state_e: FSM state encoding
//   - digit_to_ascii(): digit value -> ASCII character
package pwcrack_pkg;

   localparam logic [7:0]  CharLetterLo = 8'h61;  // 'a'
   localparam logic [7:0]  CharLetterHi = 8'h7a;  // 'z'
   localparam logic [7:0]  CharNumLo    = 8'h30;  // '0'
   localparam logic [7:0]  CharNumHi    = 8'h39;  // '9'
   localparam int unsigned NumLetters   = 26;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2,
      StDone  = 2'd3
   } state_e;

   function automatic logic [7:0] digit_to_ascii(input logic [7:0] digit);
      if (digit < 8'(NumLetters)) begin
         return CharLetterLo + digit;
      end
      return CharNumLo + (digit - 8'(NumLetters));
   endfunction

endpackage

// File: rtl/base_n_counter.sv
// Multi-digit base-RADIX counter used as the candidate generator.
//   clk, rst   : clock, synchronous active-high reset
//   load       : load load_val (takes priority over en)
//   load_val   : packed digits, digit 0 in the LS DIGIT_W bits
//   en         : advance by one; LS digit counts 0..RADIX-1 and carries upward
//   end_ms     : MS digit value of the final candidate
//   digits     : current packed digits
//   last       : MS digit == end_ms and every lower digit == RADIX-1
module base_n_counter #(
   parameter int unsigned NUM_CHARS = 4,
   parameter int unsigned RADIX     = 36,
   parameter int unsigned DIGIT_W   = 6
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         load,
   input  logic [NUM_CHARS*DIGIT_W-1:0] load_val,
   input  logic                         en,
   input  logic [DIGIT_W-1:0]           end_ms,
   output logic [NUM_CHARS*DIGIT_W-1:0] digits,
   output logic                         last
);

   localparam int unsigned   CW     = NUM_CHARS * DIGIT_W;
   localparam logic [DIGIT_W-1:0] DigMax = DIGIT_W'(RADIX - 1);

   logic [CW-1:0] digits_q, digits_d;
   logic          carry;

   always_comb begin
      digits_d = digits_q;
      carry    = en;
      for (int i = 0; i < int'(NUM_CHARS); i++) begin
         if (carry) begin
            if (digits_q[i*DIGIT_W +: DIGIT_W] == DigMax) begin
               digits_d[i*DIGIT_W +: DIGIT_W] = '0;
            end else begin
               digits_d[i*DIGIT_W +: DIGIT_W] = digits_q[i*DIGIT_W +: DIGIT_W] + 1'b1;
               carry = 1'b0;
            end
         end
      end
      if (load) begin
         digits_d = load_val;
      end
   end

   always_comb begin
      last = (digits_q[(NUM_CHARS-1)*DIGIT_W +: DIGIT_W] == end_ms);
      for (int i = 0; i < int'(NUM_CHARS) - 1; i++) begin
         if (digits_q[i*DIGIT_W +: DIGIT_W] != DigMax) begin
            last = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         digits_q <= '0;
      end else begin
         digits_q <= digits_d;
      end
   end

   assign digits = digits_q;

endmodule

// File: rtl/password_search_engine.sv
// Brute-force candidate enumerator with in-line comparator, one candidate per clock.
//   clk, rst       : clock, synchronous active-high reset
//   start          : begin a search (IDLE only); captures target, range and mode
//   abort          : cancel a search (RUN/DRAIN), no done pulse
//   stop_on_match  : 1 = stop at first match, 0 = sweep whole range
//   target         : ASCII password, char 0 in MS byte
//   range_lo/hi    : inclusive MS-digit range to enumerate
//   busy           : high in RUN and DRAIN
//   done           : one-cycle pulse when a search completes
//   found/found_pw : match seen / ASCII of first match
//   match_count    : matches, saturating at 255
//   cand_count     : candidates compared, saturating
module password_search_engine
   import pwcrack_pkg::*;
#(
   parameter int unsigned NUM_CHARS = 4,
   parameter int unsigned RADIX     = 36,
   parameter int unsigned DIGIT_W   = 6,
   parameter int unsigned CNT_W     = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic                   stop_on_match,
   input  logic [NUM_CHARS*8-1:0] target,
   input  logic [DIGIT_W-1:0]     range_lo,
   input  logic [DIGIT_W-1:0]     range_hi,
   output logic                   busy,
   output logic                   done,
   output logic                   found,
   output logic [NUM_CHARS*8-1:0] found_pw,
   output logic [7:0]             match_count,
   output logic [CNT_W-1:0]       cand_count
);

   localparam int unsigned PW_W = NUM_CHARS * 8;
   localparam int unsigned CW   = NUM_CHARS * DIGIT_W;

   state_e             state_q, state_d;
   logic [PW_W-1:0]    target_q, target_d;
   logic [DIGIT_W-1:0] range_hi_q, range_hi_d;
   logic               stop_q, stop_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               found_q, found_d;
   logic [PW_W-1:0]    found_pw_q, found_pw_d;
   logic [7:0]         match_cnt_q, match_cnt_d;
   logic [CNT_W-1:0]   cand_cnt_q, cand_cnt_d;
   // Stage 1: registered ASCII candidate
   logic [PW_W-1:0]    cand_q, cand_d;
   logic               cand_vld_q, cand_vld_d;

   logic               cnt_load, cnt_en, cnt_last;
   logic [CW-1:0]      cnt_load_val, cnt_digits;
   logic [PW_W-1:0]    cand_ascii;
   logic               range_ok, match;

   base_n_counter #(
      .NUM_CHARS (NUM_CHARS),
      .RADIX     (RADIX),
      .DIGIT_W   (DIGIT_W)
   ) u_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .en       (cnt_en),
      .end_ms   (range_hi_q),
      .digits   (cnt_digits),
      .last     (cnt_last)
   );

   always_comb begin
      cnt_load_val = '0;
      cnt_load_val[(NUM_CHARS-1)*DIGIT_W +: DIGIT_W] = range_lo;
   end

   always_comb begin
      cand_ascii = '0;
      for (int i = 0; i < int'(NUM_CHARS); i++) begin
         cand_ascii[i*8 +: 8] = digit_to_ascii(8'(cnt_digits[i*DIGIT_W +: DIGIT_W]));
      end
   end

   assign range_ok = (range_lo <= range_hi) && (32'(range_hi) < RADIX);
   // Candidates are always in-charset, so an out-of-charset target byte never matches.
   assign match    = cand_vld_q && (cand_q == target_q);

   always_comb begin
      state_d     = state_q;
      target_d    = target_q;
      range_hi_d  = range_hi_q;
      stop_d      = stop_q;
      found_d     = found_q;
      found_pw_d  = found_pw_q;
      match_cnt_d = match_cnt_q;
      cand_cnt_d  = cand_cnt_q;
      cand_d      = cand_q;
      cand_vld_d  = 1'b0;
      cnt_load    = 1'b0;
      cnt_en      = 1'b0;

      // Retire the stage-1 compare into the result registers.
      if (cand_vld_q) begin
         if (cand_cnt_q != '1) begin
            cand_cnt_d = cand_cnt_q + 1'b1;
         end
         if (match) begin
            found_d = 1'b1;
            if (match_cnt_q != 8'hff) begin
               match_cnt_d = match_cnt_q + 8'd1;
            end
            if (!found_q) begin
               found_pw_d = cand_q;
            end
         end
      end

      unique case (state_q)
         StIdle: begin
            if (start) begin
               target_d    = target;
               range_hi_d  = range_hi;
               stop_d      = stop_on_match;
               found_d     = 1'b0;
               found_pw_d  = '0;
               match_cnt_d = '0;
               cand_cnt_d  = '0;
               if (range_ok) begin
                  cnt_load = 1'b1;
                  state_d  = StRun;
               end else begin
                  state_d  = StDone;
               end
            end
         end
         StRun: begin
            if (abort) begin
               state_d = StIdle;
            end else if (stop_q && match) begin
               // Hold the candidate currently in stage 0; it is never presented.
               state_d = StDrain;
            end else begin
               cand_d     = cand_ascii;
               cand_vld_d = 1'b1;
               if (cnt_last) begin
                  state_d = StDrain;
               end else begin
                  cnt_en = 1'b1;
               end
            end
         end
         StDrain: begin
            state_d = abort ? StIdle : StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      busy_d = (state_d == StRun) || (state_d == StDrain);
      done_d = (state_d == StDone);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         target_q    <= '0;
         range_hi_q  <= '0;
         stop_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         found_q     <= 1'b0;
         found_pw_q  <= '0;
         match_cnt_q <= '0;
         cand_cnt_q  <= '0;
         cand_q      <= '0;
         cand_vld_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         target_q    <= target_d;
         range_hi_q  <= range_hi_d;
         stop_q      <= stop_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         found_q     <= found_d;
         found_pw_q  <= found_pw_d;
         match_cnt_q <= match_cnt_d;
         cand_cnt_q  <= cand_cnt_d;
         cand_q      <= cand_d;
         cand_vld_q  <= cand_vld_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign found       = found_q;
   assign found_pw    = found_pw_q;
   assign match_count = match_cnt_q;
   assign cand_count  = cand_cnt_q;

endmodule

// File: tb/tb_password_search_engine.sv
module tb_password_search_engine;

   localparam int NC    = 2;
   localparam int RX    = 36;
   localparam int DW    = 6;
   localparam int CW    = 32;
   localparam int PW    = NC * 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          stop_on_match = 1'b0;
   logic [PW-1:0] target = '0;
   logic [DW-1:0] range_lo = '0;
   logic [DW-1:0] range_hi = '0;
   logic          busy, done, found;
   logic [PW-1:0] found_pw;
   logic [7:0]    match_count;
   logic [CW-1:0] cand_count;

   int tests = 0;
   int fails = 0;

   password_search_engine #(
      .NUM_CHARS (NC),
      .RADIX     (RX),
      .DIGIT_W   (DW),
      .CNT_W     (CW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .abort         (abort),
      .stop_on_match (stop_on_match),
      .target        (target),
      .range_lo      (range_lo),
      .range_hi      (range_hi),
      .busy          (busy),
      .done          (done),
      .found         (found),
      .found_pw      (found_pw),
      .match_count   (match_count),
      .cand_count    (cand_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] sym(input int d);
      return (d < 26) ? 8'(97 + d) : 8'(48 + d - 26);
   endfunction

   // Reference: walk every string in the range in lexicographic order.
   task automatic model(input logic [PW-1:0] tgt, input int lo, input int hi, input bit stop,
                        output bit ok, output bit f, output logic [PW-1:0] pw,
                        output int mc, output int cc);
      int span;
      logic [PW-1:0] s;
      span = 1;
      for (int k = 0; k < NC - 1; k++) span *= RX;
      ok = (lo <= hi) && (hi < RX);
      f = 0; pw = '0; mc = 0; cc = 0;
      if (ok) begin
         for (int idx = lo * span; idx < (hi + 1) * span; idx++) begin
            int v;
            v = idx;
            for (int c = 0; c < NC; c++) begin
               s[c*8 +: 8] = sym(v % RX);
               v = v / RX;
            end
            cc++;
            if (s == tgt) begin
               if (!f) pw = s;
               f = 1;
               if (mc < 255) mc++;
               if (stop) break;
            end
         end
      end
   endtask

   task automatic run_search(input string tag, input logic [PW-1:0] tgt, input int lo,
                             input int hi, input bit stop, input int extra_at);
      bit ok, ef;
      logic [PW-1:0] epw;
      int emc, ecc, lat, busy_cnt, extra_done;
      bit seen;
      model(tgt, lo, hi, stop, ok, ef, epw, emc, ecc);
      @(negedge clk);
      target = tgt; range_lo = DW'(lo); range_hi = DW'(hi); stop_on_match = stop; start = 1'b1;
      seen = 0; lat = 0; busy_cnt = 0;
      for (int c = 1; c <= 4000 && !seen; c++) begin
         @(negedge clk);
         start = (c == extra_at);
         if (done) begin
            seen = 1;
            lat = c;
         end else if (busy) begin
            busy_cnt++;
         end
      end
      start = 1'b0;
      chk({tag, "_done_seen"}, 64'(seen), 64'd1);
      if (seen) begin
         extra_done = 0;
         repeat (3) begin
            @(negedge clk);
            if (done) extra_done++;
         end
         chk({tag, "_done_single"}, 64'(extra_done), 64'd0);
         chk({tag, "_found"}, 64'(found), 64'(ef));
         chk({tag, "_found_pw"}, 64'(found_pw), 64'(epw));
         chk({tag, "_match_count"}, 64'(match_count), 64'(emc));
         chk({tag, "_cand_count"}, 64'(cand_count), 64'(ecc));
         if (!ok) begin
            chk({tag, "_latency"}, 64'(lat), 64'd1);
            chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd0);
         end else begin
            chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(lat - 1));
            if (!stop) chk({tag, "_latency"}, 64'(lat), 64'(ecc + 2));
         end
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_found"}, 64'(found), 64'd0);
      chk({tag, "_found_pw"}, 64'(found_pw), 64'd0);
      chk({tag, "_match_count"}, 64'(match_count), 64'd0);
      chk({tag, "_cand_count"}, 64'(cand_count), 64'd0);
   endtask

   initial begin
      int dcnt;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_zero("reset");

      // Directed scenarios
      run_search("t1_ab_stop", "ab", 0, 0, 1'b1, 0);
      run_search("t2_zz_sweep", "zz", 0, 35, 1'b0, 0);
      run_search("t3_b9", "b9", 1, 1, 1'b0, 0);
      run_search("t4_bad_range", "aa", 5, 3, 1'b0, 0);
      run_search("t4b_hi_oob", "aa", 2, 40, 1'b1, 0);

      // Abort 10 cycles into a full sweep
      @(negedge clk);
      target = "zz"; range_lo = 0; range_hi = 35; stop_on_match = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("t5_abort_busy", 64'(busy), 64'd0);
      dcnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) dcnt++;
      end
      chk("t5_abort_quiet", 64'(dcnt), 64'd0);
      run_search("t5_after_abort", "c7", 2, 2, 1'b0, 0);

      // Extra start while busy must not disturb the search
      run_search("t6_extra_start", "e0", 3, 6, 1'b0, 5);

      // Reset mid-RUN
      @(negedge clk);
      target = "zz"; range_lo = 0; range_hi = 35; stop_on_match = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (30) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_zero("t6_rst");
      dcnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      chk("t6_rst_no_done", 64'(dcnt), 64'd0);

      // Randomized searches
      for (int n = 0; n < 16; n++) begin
         int lo, hi;
         logic [PW-1:0] t;
         bit st;
         lo = $urandom_range(0, 35);
         hi = lo + $urandom_range(0, 3);
         if (hi > 35) hi = 35;
         if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 0 && lo > 0) hi = lo - 1;
            else hi = $urandom_range(36, 63);
         end
         t[PW-1 -: 8] = sym($urandom_range(lo, (hi < 36 && hi >= lo) ? hi : lo));
         for (int c = 0; c < NC - 1; c++) begin
            if ($urandom_range(0, 9) == 0) t[c*8 +: 8] = 8'(65 + $urandom_range(0, 25));
            else t[c*8 +: 8] = sym($urandom_range(0, 35));
         end
         st = 1'($urandom_range(0, 1));
         run_search($sformatf("rnd%0d", n), t, lo, hi, st, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
